ir_byte_tx: RTL and testbench
=============================

Name: ir_byte_tx

Overview:
Transmit end of the 8-bit instruction byte bus. Accepts 16-bit opcode/IR-address words from the fetch side into a small FIFO and serialises each word onto data[7:0] as two consecutive ena-qualified bytes, high byte first. The instruction-register loader on the other end captures them. Words may stream back-to-back with ena held high; ena drops only between words, which re-aligns the receiver's byte phase.

Parameters:
WORD_W, 16, word width; fixed at 2*BYTE_W.
BYTE_W, 8, bus byte width.
DEPTH, 2, FIFO entries; power of 2, >=2.

Ports:
clk1  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
wr_en  in  1  push request for wr_data.
wr_data  in  WORD_W  word to send; [15:8] opcode byte, [7:0] address byte.
full  out  1  FIFO holds DEPTH words; a push is ignored.
overflow  out  1  sticky; set by wr_en while full; cleared only by reset.
hold  in  1  inhibits starting a new word; sampled only at word boundaries.
ena  out  1  byte strobe to the receiver.
data  out  BYTE_W  byte on the bus; 0 whenever ena=0.
word_sent  out  1  one-cycle pulse, high during the low-byte cycle.
busy  out  1  (state!=IDLE) or FIFO non-empty.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; FIFO empty; ena=0, data=0, word_sent=0, full=0, overflow=0, busy=0. Release takes effect on the next clk1 edge.
- All outputs are registered; no combinational path from inputs to outputs.
- Push: on an edge with wr_en=1 and full=0, wr_data is stored.
  - wr_en with full=1: the word is dropped and overflow is set, even if a pop occurs on the same edge.
  - full and count update on the same edge.
- FSM states: IDLE, HI, LO.
  - IDLE: at an edge with FIFO non-empty and hold=0, pop the head into shift reg; next state HI, ena=1, data=word[15:8]. Otherwise stay in IDLE with ena=0, data=0.
  - HI: unconditionally go to LO, ena=1, data=word[7:0], word_sent=1. hold and FIFO state are ignored mid-word.
  - LO: at the edge, if FIFO non-empty and hold=0, pop the next word and go to HI with ena kept at 1 (no gap). Otherwise go to IDLE with ena=0, data=0.
- Latency: a word pushed into an empty idle block at edge k gives hi byte during k+1..k+2 and lo byte during k+2..k+3.
- A word pushed during an active word is sent gap-free after it.
- Sustained throughput: one word per 2 cycles.
- Invariant: ena never lasts an odd number of consecutive cycles. Every ena run length is 2*N.
- Simultaneous push and pop on the same edge: count is unchanged and both take effect. A push into an empty FIFO cannot be popped on the same edge.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Reset mid-word: the word in flight and all queued words are discarded, and ena=0 immediately.

Decomposition:
- Package risc_bus_pkg holds BYTE_W, WORD_W and the FSM state encoding (IDLE=2'd0, HI=2'd1, LO=2'd2).
- Sub-module byte_tx_fifo holds the synchronous FIFO: storage, pointers, count, full/empty and overflow.
- ir_byte_tx holds the FSM, shift register and output registers.

Test Plan:
- Reset, then push 16'hA55A with hold=0 -> next cycle ena=1, data=8'hA5; following cycle ena=1, data=8'h5A, word_sent=1; then ena=0, data=8'h00, busy=0.
- Push 16'h1234 and 16'hABCD on consecutive edges -> ena high for exactly 4 cycles, data 12,34,AB,CD; word_sent high on the 2nd and 4th cycles.
- Raise hold with 2 words queued; drop hold 5 cycles later -> no ena while held; the sequence starts on the edge after hold falls.
- Raise hold in the cycle data=hi of 16'h0F0F -> lo byte 8'h0F still follows and ena ends after 2 cycles.
- hold=1, push 3 words with DEPTH=2 -> full=1 after the 2nd push; the 3rd is dropped and overflow=1. Releasing hold sends exactly the first 2 words, and overflow stays set.
- Assert rst low in a HI cycle -> ena=0, data=0, full=0, busy=0 immediately. After release, no queued bytes appear until a new push.

Source files
------------

// File: rtl/risc_bus_pkg.sv
// Shared widths and FSM state encoding for the 8-bit instruction byte bus.
package risc_bus_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 2 * BYTE_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HI   = 2'd1;
  localparam logic [1:0] LO   = 2'd2;
endpackage

// File: rtl/byte_tx_fifo.sv
// Synchronous word FIFO feeding the byte serialiser; flags overflow stickily.
module byte_tx_fifo #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              overflow
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign push  = wr_en && !full;
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk1) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/ir_byte_tx.sv
// Serialises queued 16-bit opcode/address words onto the byte bus, high byte first,
// gap-free while words are available.
module ir_byte_tx
  import risc_bus_pkg::*;
#(
  parameter int WORD_W = risc_bus_pkg::WORD_W,
  parameter int BYTE_W = risc_bus_pkg::BYTE_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  output logic              full,
  output logic              overflow,
  input  logic              hold,
  output logic              ena,
  output logic [BYTE_W-1:0] data,
  output logic              word_sent,
  output logic              busy
);
  logic [1:0]        state;
  logic [BYTE_W-1:0] lo_byte;
  logic [WORD_W-1:0] head;
  logic              empty;
  logic              pop;

  byte_tx_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk1     (clk1),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  // New words start only at a word boundary (IDLE or the low-byte cycle).
  assign pop  = (state != HI) && !empty && !hold;
  assign busy = (state != IDLE) || !empty;

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ena       <= 1'b0;
      data      <= '0;
      word_sent <= 1'b0;
    end else if (state == HI) begin
      state     <= LO;
      ena       <= 1'b1;
      data      <= lo_byte;
      word_sent <= 1'b1;
    end else if (pop) begin
      state     <= HI;
      ena       <= 1'b1;
      data      <= head[WORD_W-1:BYTE_W];
      word_sent <= 1'b0;
    end else begin
      state     <= IDLE;
      ena       <= 1'b0;
      data      <= '0;
      word_sent <= 1'b0;
    end
  end

  always_ff @(posedge clk1) begin
    if (pop) lo_byte <= head[BYTE_W-1:0];
  end
endmodule

// File: tb/tb_ir_byte_tx.sv
// Directed and randomized bench for ir_byte_tx against a queue-based model of the byte stream.
module tb_ir_byte_tx;
  localparam int DEPTH = 2;

  logic        clk1;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        overflow;
  logic        hold;
  logic        ena;
  logic [7:0]  data;
  logic        word_sent;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int run_len = 0;

  logic [15:0] q[$];
  logic        m_ena, m_ws, m_ovf;
  logic [7:0]  m_data, m_lo;

  ir_byte_tx #(.WORD_W(16), .BYTE_W(8), .DEPTH(DEPTH)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .overflow  (overflow),
    .hold      (hold),
    .ena       (ena),
    .data      (data),
    .word_sent (word_sent),
    .busy      (busy)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_ena = 1'b0; m_ws = 1'b0; m_ovf = 1'b0; m_data = 8'h00; m_lo = 8'h00;
    run_len = 0;
  endtask

  // One clock edge of the bus: finish a started word, else start the next queued one.
  task automatic model_edge(input logic we, input logic [15:0] wd, input logic hd);
    int pre;
    logic [15:0] w;
    pre = q.size();
    if (m_ena && !m_ws) begin
      m_data = m_lo;
      m_ws   = 1'b1;
    end else if (pre != 0 && !hd) begin
      w      = q.pop_front();
      m_ena  = 1'b1;
      m_data = w[15:8];
      m_lo   = w[7:0];
      m_ws   = 1'b0;
    end else begin
      m_ena  = 1'b0;
      m_data = 8'h00;
      m_ws   = 1'b0;
    end
    if (we) begin
      if (pre == DEPTH) m_ovf = 1'b1;
      else q.push_back(wd);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_ena"},  16'(ena),       16'(m_ena));
    chk({tag, "_data"}, 16'(data),      16'(m_data));
    chk({tag, "_ws"},   16'(word_sent), 16'(m_ws));
    chk({tag, "_full"}, 16'(full),      16'(q.size() == DEPTH));
    chk({tag, "_ovf"},  16'(overflow),  16'(m_ovf));
    chk({tag, "_busy"}, 16'(busy),      16'(m_ena || q.size() != 0));
    if (ena) run_len++;
    else begin
      if (run_len != 0) chk({tag, "_even_run"}, 16'(run_len % 2), 16'd0);
      run_len = 0;
    end
  endtask

  task automatic step(input string tag, input logic we, input logic [15:0] wd, input logic hd);
    wr_en = we; wr_data = wd; hold = hd;
    @(posedge clk1);
    model_edge(we, wd, hd);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = 16'h0000; hold = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;
    step("idle", 0, 16'h0000, 0);

    // Single word, with latency pinned to constants.
    step("a55a_push", 1, 16'hA55A, 0);
    step("a55a_hi", 0, 16'h0000, 0);
    chk("a55a_hi_byte", 16'(data), 16'h00A5);
    step("a55a_lo", 0, 16'h0000, 0);
    chk("a55a_lo_byte", 16'(data), 16'h005A);
    chk("a55a_lo_ws", 16'(word_sent), 16'd1);
    step("a55a_end", 0, 16'h0000, 0);
    chk("a55a_end_busy", 16'(busy), 16'd0);

    // Back-to-back words, no gap.
    step("b2b_p1", 1, 16'h1234, 0);
    step("b2b_p2", 1, 16'hABCD, 0);
    chk("b2b_first", 16'(data), 16'h0012);
    step("b2b_c2", 0, 16'h0000, 0);
    step("b2b_c3", 0, 16'h0000, 0);
    chk("b2b_third", 16'(data), 16'h00AB);
    step("b2b_c4", 0, 16'h0000, 0);
    chk("b2b_fourth", 16'(data), 16'h00CD);
    step("b2b_end", 0, 16'h0000, 0);

    // Hold with two queued words.
    step("hold_p1", 1, 16'h1111, 1);
    step("hold_p2", 1, 16'h2222, 1);
    for (int i = 0; i < 5; i++) step("hold_wait", 0, 16'h0000, 1);
    step("hold_rel", 0, 16'h0000, 0);
    chk("hold_rel_hi", 16'(data), 16'h0011);
    for (int i = 0; i < 4; i++) step("hold_drain", 0, 16'h0000, 0);

    // Hold raised mid-word is ignored.
    step("mid_push", 1, 16'h0F0F, 0);
    step("mid_hi", 0, 16'h0000, 0);
    step("mid_lo", 0, 16'h0000, 1);
    chk("mid_lo_byte", 16'(data), 16'h000F);
    step("mid_end", 0, 16'h0000, 1);
    chk("mid_end_ena", 16'(ena), 16'd0);

    // Overflow while held.
    step("ovf_p1", 1, 16'hC001, 1);
    step("ovf_p2", 1, 16'hC002, 1);
    chk("ovf_full", 16'(full), 16'd1);
    step("ovf_p3", 1, 16'hC003, 1);
    chk("ovf_flag", 16'(overflow), 16'd1);
    for (int i = 0; i < 6; i++) step("ovf_drain", 0, 16'h0000, 0);
    chk("ovf_sticky", 16'(overflow), 16'd1);

    // Reset during a high-byte cycle.
    step("rst_p1", 1, 16'hDEAD, 0);
    step("rst_p2", 1, 16'hBEEF, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    #3;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step("rst_after", 0, 16'h0000, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) == 0));
    for (int i = 0; i < 8; i++) step("rand_drain", 0, 16'h0000, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
